// File: rtl/fetch_hazard_ctrl.sv
// Fetch-stage sequencing controller: boot wait, load-use stall, taken-branch flush, sticky halt,
// plus saturating stall/flush event counters.
module fetch_hazard_ctrl #(
  parameter int unsigned BOOT_CYCLES  = 1,
  parameter int unsigned STALL_CYCLES = 1,
  parameter int unsigned CNT_W        = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ex_mem_read,
  input  logic [4:0]       ex_rt,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic             id_uses_rt,
  input  logic             branch_taken,
  input  logic             halt_req,
  output logic             pc_write,
  output logic             pc_src,
  output logic             if_id_write,
  output logic             if_id_flush,
  output logic             id_ex_bubble,
  output logic             halted,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam int unsigned BW = $clog2(BOOT_CYCLES + 1);
  localparam int unsigned SW = $clog2(STALL_CYCLES + 1);
  localparam logic [BW-1:0] BootInit  = BW'(BOOT_CYCLES - 1);
  localparam logic [SW-1:0] StallInit = SW'(STALL_CYCLES - 1);
  localparam bit MultiStall = (STALL_CYCLES > 1);

  typedef enum logic [2:0] {StBoot, StRun, StStall, StFlush, StHalt} state_e;

  state_e           state_q, state_d;
  logic [BW-1:0]    boot_q, boot_d;
  logic [SW-1:0]    rem_q, rem_d;
  logic [CNT_W-1:0] stall_cnt_q, flush_cnt_q;
  logic             stall_inc, flush_inc;
  logic             hz;

  assign hz = ex_mem_read && (ex_rt != 5'd0) &&
              ((ex_rt == id_rs) || (id_uses_rt && (ex_rt == id_rt)));

  always_comb begin
    state_d      = state_q;
    boot_d       = boot_q;
    rem_d        = rem_q;
    pc_write     = 1'b0;
    pc_src       = 1'b0;
    if_id_write  = 1'b0;
    if_id_flush  = 1'b0;
    id_ex_bubble = 1'b0;
    halted       = 1'b0;
    stall_inc    = 1'b0;
    flush_inc    = 1'b0;

    unique case (state_q)
      StBoot: begin
        if_id_flush  = 1'b1;
        id_ex_bubble = 1'b1;
        if (halt_req) begin
          state_d = StHalt;
        end else if (boot_q == '0) begin
          state_d = StRun;
        end else begin
          boot_d = boot_q - 1'b1;
        end
      end
      StRun: begin
        if (halt_req) begin
          id_ex_bubble = 1'b1;
          state_d      = StHalt;
        end else if (hz) begin
          id_ex_bubble = 1'b1;
          stall_inc    = 1'b1;
          if (MultiStall) begin
            state_d = StStall;
            rem_d   = StallInit;
          end
        end else if (branch_taken) begin
          pc_write    = 1'b1;
          pc_src      = 1'b1;
          if_id_write = 1'b1;
          if_id_flush = 1'b1;
          flush_inc   = 1'b1;
          state_d     = StFlush;
        end else begin
          pc_write    = 1'b1;
          if_id_write = 1'b1;
        end
      end
      StStall: begin
        id_ex_bubble = 1'b1;
        stall_inc    = 1'b1;
        if (halt_req) begin
          state_d = StHalt;
        end else if (rem_q <= SW'(1)) begin
          rem_d   = '0;
          state_d = StRun;
        end else begin
          rem_d = rem_q - 1'b1;
        end
      end
      // One extra squash slot: the synchronous imem still returns the wrong-path word.
      StFlush: begin
        pc_write    = 1'b1;
        if_id_write = 1'b1;
        if_id_flush = 1'b1;
        state_d     = halt_req ? StHalt : StRun;
      end
      StHalt: begin
        id_ex_bubble = 1'b1;
        halted       = 1'b1;
      end
      default: state_d = StBoot;
    endcase

    // Reset overrides the current state's outputs in the same cycle.
    if (rst) begin
      pc_write     = 1'b0;
      pc_src       = 1'b0;
      if_id_write  = 1'b0;
      if_id_flush  = 1'b1;
      id_ex_bubble = 1'b1;
      halted       = 1'b0;
      stall_inc    = 1'b0;
      flush_inc    = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StBoot;
      boot_q      <= BootInit;
      rem_q       <= '0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q <= state_d;
      boot_q  <= boot_d;
      rem_q   <= rem_d;
      if (stall_inc && (stall_cnt_q != '1)) stall_cnt_q <= stall_cnt_q + 1'b1;
      if (flush_inc && (flush_cnt_q != '1)) flush_cnt_q <= flush_cnt_q + 1'b1;
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;

endmodule

// File: tb/tb_fetch_hazard_ctrl.sv
// Directed bench for fetch_hazard_ctrl: three instances (default, 3-cycle stall, 4-bit counters)
// share one stimulus stream; each check compares against hand-computed values.
module tb_fetch_hazard_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       ex_mem_read;
  logic [4:0] ex_rt, id_rs, id_rt;
  logic       id_uses_rt, branch_taken, halt_req;

  logic        a_pcw, a_src, a_ifw, a_fl, a_bub, a_halt;
  logic [15:0] a_scnt, a_fcnt;
  logic        b_pcw, b_src, b_ifw, b_fl, b_bub, b_halt;
  logic [15:0] b_scnt, b_fcnt;
  logic        c_pcw, c_src, c_ifw, c_fl, c_bub, c_halt;
  logic [3:0]  c_scnt, c_fcnt;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  fetch_hazard_ctrl #(.BOOT_CYCLES(1), .STALL_CYCLES(1), .CNT_W(16)) dut_a (
    .clk(clk), .rst(rst), .ex_mem_read(ex_mem_read), .ex_rt(ex_rt), .id_rs(id_rs),
    .id_rt(id_rt), .id_uses_rt(id_uses_rt), .branch_taken(branch_taken), .halt_req(halt_req),
    .pc_write(a_pcw), .pc_src(a_src), .if_id_write(a_ifw), .if_id_flush(a_fl),
    .id_ex_bubble(a_bub), .halted(a_halt), .stall_cnt(a_scnt), .flush_cnt(a_fcnt)
  );

  fetch_hazard_ctrl #(.BOOT_CYCLES(1), .STALL_CYCLES(3), .CNT_W(16)) dut_b (
    .clk(clk), .rst(rst), .ex_mem_read(ex_mem_read), .ex_rt(ex_rt), .id_rs(id_rs),
    .id_rt(id_rt), .id_uses_rt(id_uses_rt), .branch_taken(branch_taken), .halt_req(halt_req),
    .pc_write(b_pcw), .pc_src(b_src), .if_id_write(b_ifw), .if_id_flush(b_fl),
    .id_ex_bubble(b_bub), .halted(b_halt), .stall_cnt(b_scnt), .flush_cnt(b_fcnt)
  );

  fetch_hazard_ctrl #(.BOOT_CYCLES(1), .STALL_CYCLES(1), .CNT_W(4)) dut_c (
    .clk(clk), .rst(rst), .ex_mem_read(ex_mem_read), .ex_rt(ex_rt), .id_rs(id_rs),
    .id_rt(id_rt), .id_uses_rt(id_uses_rt), .branch_taken(branch_taken), .halt_req(halt_req),
    .pc_write(c_pcw), .pc_src(c_src), .if_id_write(c_ifw), .if_id_flush(c_fl),
    .id_ex_bubble(c_bub), .halted(c_halt), .stall_cnt(c_scnt), .flush_cnt(c_fcnt)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic set_hz(input logic on);
    ex_mem_read = on;
    ex_rt       = on ? 5'd5 : 5'd0;
    id_rs       = on ? 5'd5 : 5'd0;
    id_rt       = 5'd0;
    id_uses_rt  = 1'b0;
  endtask

  initial begin
    rst = 1'b1; halt_req = 1'b0; branch_taken = 1'b0;
    set_hz(1'b0);

    // Reset held for two edges
    tick(); tick();
    check("rst_pcw", a_pcw, 0);
    check("rst_flush", a_fl, 1);
    check("rst_bubble", a_bub, 1);
    check("rst_halted", a_halt, 0);
    check("rst_scnt", a_scnt, 0);
    check("rst_fcnt", a_fcnt, 0);

    rst = 1'b0; #1;
    check("boot_pcw", a_pcw, 0);
    check("boot_flush", a_fl, 1);
    check("boot_ifw", a_ifw, 0);

    tick();
    check("run_pcw", a_pcw, 1);
    check("run_ifw", a_ifw, 1);
    check("run_flush", a_fl, 0);
    check("run_src", a_src, 0);
    check("run_halted", a_halt, 0);

    // Load of r0 never hazards
    ex_mem_read = 1'b1; ex_rt = 5'd0; id_rs = 5'd0; #1;
    check("r0_pcw", a_pcw, 1);
    check("r0_bubble", a_bub, 0);

    // rt match ignored unless rt is a source
    tick();
    ex_rt = 5'd7; id_rs = 5'd3; id_rt = 5'd7; id_uses_rt = 1'b0; #1;
    check("rt_unused_pcw", a_pcw, 1);

    tick();
    id_uses_rt = 1'b1; #1;
    check("rt_hz_pcw", a_pcw, 0);
    check("rt_hz_ifw", a_ifw, 0);
    check("rt_hz_bubble", a_bub, 1);
    check("rt_hz_b_pcw", b_pcw, 0);

    tick();
    set_hz(1'b0); #1;
    check("after_hz_a_pcw", a_pcw, 1);
    check("after_hz_a_scnt", a_scnt, 1);
    check("stall1_b_pcw", b_pcw, 0);
    check("stall1_b_scnt", b_scnt, 1);
    tick();
    check("stall2_b_pcw", b_pcw, 0);
    check("stall2_b_scnt", b_scnt, 2);
    tick();
    check("stall_end_b_pcw", b_pcw, 1);
    check("stall_end_b_scnt", b_scnt, 3);
    check("stall_end_a_scnt", a_scnt, 1);

    // Taken branch then one imem-latency flush cycle
    branch_taken = 1'b1; #1;
    check("br_src", a_src, 1);
    check("br_pcw", a_pcw, 1);
    check("br_flush", a_fl, 1);
    check("br_ifw", a_ifw, 1);
    tick();
    branch_taken = 1'b0; #1;
    check("fl_src", a_src, 0);
    check("fl_flush", a_fl, 1);
    check("fl_pcw", a_pcw, 1);
    check("fl_bubble", a_bub, 0);
    check("fl_fcnt", a_fcnt, 1);
    tick();
    check("post_fl_flush", a_fl, 0);
    check("post_fl_pcw", a_pcw, 1);

    // Hazard wins over a simultaneous branch
    set_hz(1'b1); branch_taken = 1'b1; #1;
    check("hzbr_pcw", a_pcw, 0);
    check("hzbr_src", a_src, 0);
    check("hzbr_b_pcw", b_pcw, 0);
    tick();
    set_hz(1'b0); #1;
    check("hzbr_run_src", a_src, 1);
    check("hzbr_run_fcnt", a_fcnt, 1);
    check("hzbr_stall_b_src", b_src, 0);
    check("hzbr_stall_b_pcw", b_pcw, 0);
    check("hzbr_a_scnt", a_scnt, 2);
    tick();
    branch_taken = 1'b0; #1;
    check("hzbr_a_fcnt", a_fcnt, 2);
    check("hzbr_b_fcnt", b_fcnt, 1);
    check("hzbr_b_scnt", b_scnt, 5);
    tick();
    check("hzbr_b_run_pcw", b_pcw, 1);
    check("hzbr_b_scnt2", b_scnt, 6);

    // Halt while dut_b sits in STALL
    set_hz(1'b1); #1;
    check("h_hz_b_bubble", b_bub, 1);
    tick();
    set_hz(1'b0); halt_req = 1'b1; #1;
    check("h_run_a_pcw", a_pcw, 0);
    check("h_run_a_ifw", a_ifw, 0);
    check("h_run_a_bubble", a_bub, 1);
    check("h_run_a_halted", a_halt, 0);
    check("h_stall_b_halted", b_halt, 0);
    tick();
    halt_req = 1'b0; #1;
    check("h_b_halted", b_halt, 1);
    check("h_b_pcw", b_pcw, 0);
    check("h_b_flush", b_fl, 0);
    check("h_b_bubble", b_bub, 1);
    check("h_a_halted", a_halt, 1);
    tick();
    branch_taken = 1'b1; set_hz(1'b1); #1;
    check("h_sticky_b", b_halt, 1);
    check("h_sticky_b_pcw", b_pcw, 0);
    check("h_sticky_b_src", b_src, 0);
    check("h_sticky_a", a_halt, 1);
    tick();
    rst = 1'b1; branch_taken = 1'b0; set_hz(1'b0); #1;
    check("h_rst_halted", b_halt, 0);
    check("h_rst_flush", b_fl, 1);
    check("h_rst_pcw", b_pcw, 0);
    tick();
    rst = 1'b0; #1;
    check("h_boot_pcw", b_pcw, 0);
    check("h_boot_halted", b_halt, 0);
    check("h_boot_scnt", b_scnt, 0);
    check("h_boot_fcnt", b_fcnt, 0);
    tick();
    check("h_run_b_pcw", b_pcw, 1);

    // Continuous hazard: 4-bit counter saturates at 15
    set_hz(1'b1);
    for (int i = 0; i < 15; i++) tick();
    check("sat15_c", c_scnt, 15);
    check("sat15_a", a_scnt, 15);
    for (int i = 0; i < 5; i++) tick();
    check("sat20_c", c_scnt, 15);
    check("sat20_a", a_scnt, 20);
    check("sat20_b", b_scnt, 20);
    check("sat20_c_pcw", c_pcw, 0);
    set_hz(1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
